// File: rtl/convolution_procesor_gate_unit.sv
// N-operand registered gate (logical AND/OR/XOR, bitwise AND) with a valid/ready
// stream interface and optional accumulation of beats across a packet.
module convolution_procesor_gate_unit #(
    parameter int unsigned DATA_WIDTH = 22,
    parameter int unsigned NUM_OPS    = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_OPS*DATA_WIDTH-1:0] in_data,
    input  logic                          in_last,
    input  logic [1:0]                    mode,
    input  logic                          acc_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_bit,
    output logic [DATA_WIDTH-1:0]         out_word,
    output logic [CNT_WIDTH-1:0]          out_beats,
    output logic                          busy
);

    typedef enum logic {IDLE, ACCUM} state_e;
    typedef enum logic [1:0] {M_AND = 2'b00, M_OR = 2'b01, M_XOR = 2'b10, M_BAND = 2'b11} mode_e;

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic                  acc_bit_q, acc_bit_d;
    logic [DATA_WIDTH-1:0] acc_word_q, acc_word_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_bit_q, out_bit_d;
    logic [DATA_WIDTH-1:0] out_word_q, out_word_d;
    logic [CNT_WIDTH-1:0]  out_beats_q, out_beats_d;

    logic [NUM_OPS-1:0]    nz;
    logic [DATA_WIDTH-1:0] and_word;
    mode_e                 eff_mode;
    logic                  beat_bit;
    logic [DATA_WIDTH-1:0] beat_word;
    logic                  comb_bit;
    logic [DATA_WIDTH-1:0] comb_word;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic                  accept;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_word  = out_word_q;
    assign out_beats = out_beats_q;
    assign busy      = (state_q == ACCUM);

    always_comb begin
        nz       = '0;
        and_word = '1;
        for (int unsigned k = 0; k < NUM_OPS; k++) begin
            nz[k]    = |in_data[k*DATA_WIDTH +: DATA_WIDTH];
            and_word = and_word & in_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Inside a packet the latched mode governs every beat, not the live input.
    always_comb begin
        eff_mode  = (state_q == ACCUM) ? mode_q : mode_e'(mode);
        beat_word = (eff_mode == M_BAND) ? and_word : '0;
        case (eff_mode)
            M_AND:   beat_bit = &nz;
            M_OR:    beat_bit = |nz;
            M_XOR:   beat_bit = ^nz;
            default: beat_bit = |beat_word;
        endcase
    end

    always_comb begin
        comb_word = acc_word_q & beat_word;
        case (mode_q)
            M_AND:   comb_bit = acc_bit_q && beat_bit;
            M_OR:    comb_bit = acc_bit_q || beat_bit;
            M_XOR:   comb_bit = acc_bit_q ^ beat_bit;
            default: comb_bit = |comb_word;
        endcase
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        acc_bit_d   = acc_bit_q;
        acc_word_d  = acc_word_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_bit_d   = out_bit_q;
        out_word_d  = out_word_q;
        out_beats_d = out_beats_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d = mode_e'(mode);
                    if (!acc_en || in_last) begin
                        out_valid_d = 1'b1;
                        out_bit_d   = beat_bit;
                        out_word_d  = beat_word;
                        out_beats_d = CNT_WIDTH'(1);
                    end else begin
                        acc_bit_d  = beat_bit;
                        acc_word_d = beat_word;
                        cnt_d      = CNT_WIDTH'(1);
                        state_d    = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_bit_d  = comb_bit;
                    acc_word_d = comb_word;
                    cnt_d      = cnt_inc;
                    if (in_last) begin
                        out_valid_d = 1'b1;
                        out_bit_d   = comb_bit;
                        out_word_d  = comb_word;
                        out_beats_d = cnt_inc;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= M_AND;
            acc_bit_q   <= 1'b0;
            acc_word_q  <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_word_q  <= '0;
            out_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            acc_bit_q   <= acc_bit_d;
            acc_word_q  <= acc_word_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_word_q  <= out_word_d;
            out_beats_q <= out_beats_d;
        end
    end

endmodule

// File: tb/tb_convolution_procesor_gate_unit.sv
// Directed and scoreboarded checks of the gate unit: a 2-operand instance (A)
// and a 4-operand instance with a 4-bit beat counter (B).
`timescale 1ns/1ps
module tb_convolution_procesor_gate_unit;

    localparam int unsigned AW = 22, AN = 2, AC = 16;
    localparam int unsigned BW = 12, BN = 4, BC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic            a_in_valid, a_in_ready, a_in_last, a_acc_en, a_out_valid, a_out_ready, a_out_bit, a_busy;
    logic [AN*AW-1:0] a_in_data;
    logic [1:0]      a_mode;
    logic [AW-1:0]   a_out_word;
    logic [AC-1:0]   a_out_beats;

    logic            b_in_valid, b_in_ready, b_in_last, b_acc_en, b_out_valid, b_out_ready, b_out_bit, b_busy;
    logic [BN*BW-1:0] b_in_data;
    logic [1:0]      b_mode;
    logic [BW-1:0]   b_out_word;
    logic [BC-1:0]   b_out_beats;

    convolution_procesor_gate_unit #(.DATA_WIDTH(AW), .NUM_OPS(AN), .CNT_WIDTH(AC)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_last(a_in_last), .mode(a_mode), .acc_en(a_acc_en), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_bit(a_out_bit), .out_word(a_out_word),
        .out_beats(a_out_beats), .busy(a_busy));

    convolution_procesor_gate_unit #(.DATA_WIDTH(BW), .NUM_OPS(BN), .CNT_WIDTH(BC)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_last(b_in_last), .mode(b_mode), .acc_en(b_acc_en), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_bit(b_out_bit), .out_word(b_out_word),
        .out_beats(b_out_beats), .busy(b_busy));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic          rb;
        logic [AW-1:0] w;
        logic [AC-1:0] n;
    } res_t;

    function automatic void beat_eval(input logic [1:0] md, input logic [AW-1:0] x, input logic [AW-1:0] y,
                                      output logic rb, output logic [AW-1:0] w);
        w = '0;
        case (md)
            2'b00: rb = (x != 0) && (y != 0);
            2'b01: rb = (x != 0) || (y != 0);
            2'b10: rb = (x != 0) ^ (y != 0);
            default: begin
                w  = x & y;
                rb = (w != 0);
            end
        endcase
    endfunction

    res_t          q[$];
    res_t          r;
    logic          m_open;
    logic [1:0]    m_mode;
    logic          m_bit, e_bit;
    logic [AW-1:0] m_word, e_word, opx, opy;
    logic [AC-1:0] m_cnt;
    int            sent;
    bit            hs_in, hs_out;

    initial begin
        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = '0; a_in_last = 0; a_mode = 2'b00; a_acc_en = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_data = '0; b_in_last = 0; b_mode = 2'b00; b_acc_en = 0; b_out_ready = 1;
        tick(); tick();
        chk("rst_valid", a_out_valid, 0);
        chk("rst_bit", a_out_bit, 0);
        chk("rst_word", a_out_word, 0);
        chk("rst_beats", a_out_beats, 0);
        chk("rst_busy", a_busy, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", a_in_ready, 1);

        // Legacy two-operand logical AND
        a_in_valid = 1; a_mode = 2'b00; a_acc_en = 0; a_in_data = {22'h5, 22'h3};
        tick();
        chk("and_valid", a_out_valid, 1);
        chk("and_bit", a_out_bit, 1);
        chk("and_word", a_out_word, 0);
        chk("and_beats", a_out_beats, 1);
        a_in_data = {22'h0, 22'h3};
        tick();
        chk("and_zero_valid", a_out_valid, 1);
        chk("and_zero_bit", a_out_bit, 0);
        a_in_valid = 0;
        tick();
        chk("and_idle_valid", a_out_valid, 0);

        // Four operands: XOR parity and bitwise AND
        b_in_valid = 1; b_acc_en = 0; b_mode = 2'b10;
        b_in_data = {12'd0, 12'd7, 12'd0, 12'd1};
        tick();
        chk("xor_even", b_out_bit, 0);
        b_in_data = {12'd2, 12'd7, 12'd0, 12'd1};
        tick();
        chk("xor_odd", b_out_bit, 1);
        b_mode = 2'b11; b_in_data = {12'hF0F, 12'hF00, 12'hFF0, 12'hF0F};
        tick();
        chk("band_word", b_out_word, 12'hF00);
        chk("band_bit", b_out_bit, 1);
        b_mode = 2'b00;
        tick();
        chk("land4_word", b_out_word, 0);
        chk("land4_bit", b_out_bit, 1);
        b_in_valid = 0;
        tick();

        // Accumulated OR packet; mode change mid-packet must be ignored
        b_in_valid = 1; b_acc_en = 1; b_mode = 2'b01; b_in_last = 0; b_in_data = '0;
        tick();
        chk("acc_b1_valid", b_out_valid, 0);
        chk("acc_b1_busy", b_busy, 1);
        b_mode = 2'b00; b_acc_en = 0;
        tick();
        chk("acc_b2_valid", b_out_valid, 0);
        chk("acc_b2_busy", b_busy, 1);
        b_in_data = {12'd0, 12'd0, 12'd4, 12'd0}; b_in_last = 1;
        tick();
        chk("acc_valid", b_out_valid, 1);
        chk("acc_bit", b_out_bit, 1);
        chk("acc_beats", b_out_beats, 3);
        chk("acc_busy_end", b_busy, 0);
        b_in_valid = 0; b_in_last = 0;
        tick();
        chk("acc_idle_valid", b_out_valid, 0);

        // Backpressure holds the result and blocks input
        a_out_ready = 0; a_in_valid = 1; a_mode = 2'b00; a_acc_en = 0; a_in_data = {22'h5, 22'h3};
        tick();
        chk("bp_first_valid", a_out_valid, 1);
        a_in_data = {22'h0, 22'h3};
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", a_in_ready, 0);
            tick();
            chk("bp_hold_valid", a_out_valid, 1);
            chk("bp_hold_bit", a_out_bit, 1);
            chk("bp_hold_beats", a_out_beats, 1);
        end
        a_out_ready = 1;
        #1;
        chk("bp_release_ready", a_in_ready, 1);
        tick();
        chk("bp_b2b_valid", a_out_valid, 1);
        chk("bp_b2b_bit", a_out_bit, 0);
        a_in_valid = 0;
        tick();
        chk("bp_drain_valid", a_out_valid, 0);

        // Random scoreboard: 1000 accepted beats, random backpressure and packets
        m_open = 0; m_mode = 0; m_bit = 0; m_word = '0; m_cnt = '0; sent = 0;
        for (int cyc = 0; cyc < 20000 && (sent < 1000 || q.size() != 0); cyc++) begin
            a_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            a_out_ready = (sent >= 1000) || ($urandom_range(0, 9) < 7);
            opx = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
            opy = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
            a_in_data = {opy, opx};
            a_mode    = 2'($urandom_range(0, 3));
            a_acc_en  = 1'($urandom_range(0, 1));
            a_in_last = ($urandom_range(0, 2) == 0);
            #1;
            chk("sb_in_ready", a_in_ready, (!a_out_valid || a_out_ready) ? 1 : 0);
            hs_out = a_out_valid && a_out_ready;
            hs_in  = a_in_valid && (!a_out_valid || a_out_ready);
            if (hs_out) begin
                chk("sb_pending", (q.size() != 0) ? 1 : 0, 1);
                if (q.size() != 0) begin
                    r = q.pop_front();
                    chk("sb_bit", a_out_bit, r.rb);
                    chk("sb_word", a_out_word, r.w);
                    chk("sb_beats", a_out_beats, r.n);
                end
            end
            if (hs_in) begin
                sent++;
                if (!m_open) begin
                    beat_eval(a_mode, opx, opy, e_bit, e_word);
                    if (!a_acc_en || a_in_last) begin
                        q.push_back('{e_bit, e_word, AC'(1)});
                    end else begin
                        m_open = 1; m_mode = a_mode; m_bit = e_bit; m_word = e_word; m_cnt = AC'(1);
                    end
                end else begin
                    beat_eval(m_mode, opx, opy, e_bit, e_word);
                    case (m_mode)
                        2'b00: m_bit = m_bit && e_bit;
                        2'b01: m_bit = m_bit || e_bit;
                        2'b10: m_bit = m_bit ^ e_bit;
                        default: begin
                            m_word = m_word & e_word;
                            m_bit  = (m_word != 0);
                        end
                    endcase
                    if (m_cnt != '1) m_cnt = m_cnt + AC'(1);
                    if (a_in_last) begin
                        q.push_back('{m_bit, m_word, m_cnt});
                        m_open = 0;
                    end
                end
            end
            tick();
        end
        chk("sb_sent", sent, 1000);
        chk("sb_drained", q.size(), 0);
        a_in_valid = 0; a_out_ready = 1; a_in_last = 0;

        // Reset in the middle of an open packet
        rst_n = 0;
        tick();
        rst_n = 1;
        a_in_valid = 1; a_mode = 2'b11; a_acc_en = 0; a_in_data = {22'h3, 22'h3};
        tick();
        chk("pre_rst_word", a_out_word, 3);
        a_mode = 2'b00; a_acc_en = 1; a_in_last = 0; a_in_data = {22'h1, 22'h1};
        tick();
        chk("mid_b1_busy", a_busy, 1);
        tick();
        chk("mid_b2_busy", a_busy, 1);
        chk("mid_b2_valid", a_out_valid, 0);
        a_in_valid = 0; rst_n = 0;
        tick();
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_bit", a_out_bit, 0);
        chk("mid_rst_word", a_out_word, 0);
        chk("mid_rst_beats", a_out_beats, 0);
        chk("mid_rst_busy", a_busy, 0);
        rst_n = 1;
        tick();
        chk("mid_rst_ready", a_in_ready, 1);
        a_in_valid = 1; a_mode = 2'b00; a_acc_en = 0; a_in_data = {22'h5, 22'h5};
        tick();
        chk("post_rst_valid", a_out_valid, 1);
        chk("post_rst_bit", a_out_bit, 1);
        chk("post_rst_beats", a_out_beats, 1);
        chk("post_rst_busy", a_busy, 0);
        a_in_valid = 0;
        tick();

        // Counter saturation on the 4-bit instance
        b_in_valid = 1; b_acc_en = 1; b_mode = 2'b00;
        b_in_data = {12'd4, 12'd3, 12'd2, 12'd1};
        for (int i = 0; i < 20; i++) begin
            b_in_last = (i == 19);
            tick();
            if (i == 15) chk("sat_mid_valid", b_out_valid, 0);
        end
        chk("sat_valid", b_out_valid, 1);
        chk("sat_beats", b_out_beats, 4'hF);
        chk("sat_bit", b_out_bit, 1);
        for (int i = 0; i < 20; i++) begin
            b_in_last = (i == 19);
            b_in_data = (i == 17) ? {12'd4, 12'd0, 12'd2, 12'd1} : {12'd4, 12'd3, 12'd2, 12'd1};
            tick();
        end
        chk("sat2_valid", b_out_valid, 1);
        chk("sat2_beats", b_out_beats, 4'hF);
        chk("sat2_bit", b_out_bit, 0);
        b_in_valid = 0; b_in_last = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/convolution_procesor_gate_unit.md
# convolution_procesor_gate_unit

Parametrised, registered logic-gate unit for the convolution processor datapath. It replaces the fixed two-input combinational logical AND with an N-operand gate offering four selectable modes, a valid/ready stream interface, and optional accumulation across a multi-beat packet. It sits between the sample-fetch stage and the control FSM, where it evaluates "all/any/odd taps non-zero" conditions and bitwise masks.

## Interface
- DATA_WIDTH, 22, bits per operand word (2..32)
- NUM_OPS, 2, operands per beat (2..8)
- CNT_WIDTH, 16, width of the beat counter
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat this cycle
- in_data  in  NUM_OPS*DATA_WIDTH  operands; operand k = in_data[k*DATA_WIDTH +: DATA_WIDTH]
- in_last  in  1  final beat of packet (ignored when acc_en=0)
- mode  in  2  00 logical AND, 01 logical OR, 10 logical XOR, 11 bitwise AND
- acc_en  in  1  1 = accumulate beats until in_last; 0 = one result per beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_bit  out  1  logical result
- out_word  out  DATA_WIDTH  bitwise-AND result (mode 11), else all zeros
- out_beats  out  CNT_WIDTH  beats combined into this result
- busy  out  1  packet open (state ACCUM)

## Operation
- Beat accepted when in_valid && in_ready. in_ready = !out_valid || out_ready.
- Per-beat evaluation: nz[k] = (operand k != 0). Mode 00: &nz. Mode 01: |nz. Mode 10: ^nz (odd number non-zero). Mode 11: word = bitwise AND of all operands, bit = |word.
- FSM states IDLE, ACCUM.
- IDLE, beat accepted: mode and acc_en latched. If acc_en=0 or in_last=1, result goes straight to output register, out_beats=1, stay IDLE. Otherwise accumulator loaded with beat result, count=1, go ACCUM.
- ACCUM, beat accepted: accumulator combined with beat result using latched mode (AND: &&, OR: ||, XOR: ^, mode 11: bitwise AND of words); count+1 (saturates at all-ones). If in_last: combined result to output register, out_beats=count, return IDLE; else stay ACCUM.
- mode/acc_en inputs ignored while in ACCUM; latched values govern the whole packet.
- Output register holds result, out_valid stays high until out_ready; new result may load in same cycle the old one is consumed.
- Zero-width corner: NUM_OPS=2, mode 00 reproduces legacy (A!=0)&&(B!=0).

## Timing
- Latency: accepted final beat (or single beat) -> out_valid next cycle.
- Throughput: one beat per cycle when out_ready held high.
- Non-last ACCUM beats still require in_ready; they never assert out_valid.
- Reset (rst_n=0 at a rising edge): state IDLE, out_valid=0, out_bit=0, out_word=0, out_beats=0, busy=0, accumulator and count cleared; in_ready=1 the cycle after. Open packet discarded, no partial result emitted.
- Backpressure: out_valid=1 && out_ready=0 -> in_ready=0, no beat accepted, accumulator and state frozen.
- Simultaneous consume and load: out_valid stays 1, outputs update to new result.
- Counter saturation: after 2^CNT_WIDTH-1 beats out_beats holds all-ones; logical accumulation continues correctly.
- busy=1 exactly while state is ACCUM.

## Test plan
- Single beat, NUM_OPS=2, mode 00, acc_en=0, A=0x3, B=0x5 -> next cycle out_valid=1, out_bit=1, out_word=0, out_beats=1; repeat with B=0 -> out_bit=0.
- NUM_OPS=4, mode 10, operands {1,0,7,0} -> out_bit=0; {1,0,7,2} -> out_bit=1; mode 11 operands {0xF0F,0xFF0,0xF00,0xF0F} -> out_word=0xF00, out_bit=1.
- Accumulate, mode 01, acc_en=1, three beats all-zero, all-zero, {0,4} with in_last on beat 3 -> single result out_bit=1, out_beats=3; busy high after beat 1 until beat 3 accepted; mode changed to 00 on beat 2 has no effect.
- Backpressure: out_ready=0 for 5 cycles with result pending -> in_ready=0, out_* stable; out_ready=1 and new beat same cycle -> back-to-back results, none lost or duplicated (scoreboard, 1000 random beats).
- Reset mid-packet: rst_n low after 2 of 4 accumulating beats -> all outputs zero, busy=0; next packet {5,5} mode 00 acc_en=0 -> out_bit=1, out_beats=1.
- Saturation with CNT_WIDTH=4: 20-beat packet mode 00, all non-zero -> out_beats=15, out_bit=1.
